// File: rtl/key_debounce_repeat.sv
// N-channel key conditioner. Each channel has a two-flop synchroniser, an integrating
// debouncer, registered press/release pulses and an optional hold-to-repeat auto-fire.
module key_debounce_repeat #(
    parameter int                N_KEYS          = 3,
    parameter bit                ACTIVE_LOW      = 1'b1,
    parameter int                DEBOUNCE_CYCLES = 500000,
    parameter int                REPEAT_DELAY    = 7500000,
    parameter int                REPEAT_PERIOD   = 2500000,
    parameter logic [N_KEYS-1:0] REPEAT_MASK     = {N_KEYS{1'b1}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] ikey,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    localparam logic [DB_W-1:0]  DB_LIMIT     = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [RPT_W-1:0] DELAY_LIMIT  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LIMIT = RPT_W'(REPEAT_PERIOD - 1);
    localparam logic             RAW_RELEASED = ACTIVE_LOW;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] HELD   = 2'd1;
    localparam logic [1:0] DELAY  = 2'd2;
    localparam logic [1:0] REPEAT = 2'd3;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        logic [1:0]       sync;
        logic             s;
        logic             level;
        logic [DB_W-1:0]  db_cnt;
        logic             accept;
        logic             accept_press;
        logic             accept_release;
        logic [1:0]       state;
        logic [RPT_W-1:0] rpt_cnt;
        logic             repeat_fire;
        logic             press_q;
        logic             rel_q;

        // NOTE: the synchroniser resets to the released raw level so leaving reset
        // never looks like a key edge; a held key is re-accepted from scratch.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync <= {2{RAW_RELEASED}};
            end else begin
                sync <= {sync[0], ikey[i]};
            end
        end

        assign s = ACTIVE_LOW ? ~sync[1] : sync[1];

        assign accept         = (s != level) && (db_cnt == DB_LIMIT);
        assign accept_press   = accept & s;
        assign accept_release = accept & ~s;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                level  <= 1'b0;
                db_cnt <= '0;
            end else if ((s == level) || accept) begin
                db_cnt <= '0;
                if (accept) begin
                    level <= s;
                end
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end

        assign repeat_fire = ((state == DELAY)  && (rpt_cnt == DELAY_LIMIT)) ||
                             ((state == REPEAT) && (rpt_cnt == PERIOD_LIMIT));

        // Counters only advance below their limit and clear on expiry, so they never wrap.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state   <= IDLE;
                rpt_cnt <= '0;
            end else if (accept_release) begin
                state   <= IDLE;
                rpt_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept_press) begin
                            state   <= REPEAT_MASK[i] ? DELAY : HELD;
                            rpt_cnt <= '0;
                        end
                    end
                    HELD: begin
                        rpt_cnt <= '0;
                    end
                    DELAY: begin
                        if (rpt_cnt == DELAY_LIMIT) begin
                            state   <= REPEAT;
                            rpt_cnt <= '0;
                        end else begin
                            rpt_cnt <= rpt_cnt + RPT_W'(1);
                        end
                    end
                    REPEAT: begin
                        if (rpt_cnt == PERIOD_LIMIT) begin
                            rpt_cnt <= '0;
                        end else begin
                            rpt_cnt <= rpt_cnt + RPT_W'(1);
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        rpt_cnt <= '0;
                    end
                endcase
            end
        end

        // A release suppresses any repeat expiring on the same edge.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                press_q <= 1'b0;
                rel_q   <= 1'b0;
            end else begin
                press_q <= accept_press | (repeat_fire & ~accept_release);
                rel_q   <= accept_release;
            end
        end

        assign key_level[i]   = level;
        assign key_press[i]   = press_q;
        assign key_release[i] = rel_q;
    end

endmodule

// File: tb/tb_key_debounce_repeat.sv
// Scoreboard bench for key_debounce_repeat: expected pulse edges are queued per channel
// as stimulus is driven and popped by a negedge monitor whenever a pulse appears.
module tb_key_debounce_repeat;

    localparam int         NK   = 3;
    localparam int         DB   = 4;
    localparam int         RD   = 10;
    localparam int         RP   = 3;
    localparam int         LAT  = 2 + DB;
    localparam logic [2:0] MASK = 3'b011;

    typedef struct packed {
        int   cyc;
        logic rel;
    } ev_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] ikey  = 3'b111;
    logic [2:0] key_level;
    logic [2:0] key_press;
    logic [2:0] key_release;

    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    ev_t  exp_q[NK][$];
    ev_t  got_ev;

    key_debounce_repeat #(
        .N_KEYS         (3),
        .ACTIVE_LOW     (1'b1),
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP),
        .REPEAT_MASK    (MASK)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ikey       (ikey),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Monitor: every observed pulse is compared against the head of its channel queue.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            for (int ch = 0; ch < NK; ch++) begin
                if (key_press[ch] || key_release[ch]) begin
                    total++;
                    if (key_press[ch] && key_release[ch]) begin
                        bad++;
                        $display("FAIL both_pulses ch=%0d cycle=%0d got press=1 release=1 want exclusive",
                                 ch, cyc);
                    end
                    total++;
                    if (exp_q[ch].size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_pulse ch=%0d cycle=%0d got press=%b release=%b want none",
                                 ch, cyc, key_press[ch], key_release[ch]);
                    end else begin
                        got_ev = exp_q[ch].pop_front();
                        if (got_ev.cyc !== cyc || got_ev.rel !== key_release[ch]) begin
                            bad++;
                            $display("FAIL pulse ch=%0d got cycle=%0d release=%b want cycle=%0d release=%b",
                                     ch, cyc, key_release[ch], got_ev.cyc, got_ev.rel);
                        end
                    end
                end
            end
        end
    end

    task automatic run_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Expected pulses for a key pressed before edge b and released before edge b+e.
    task automatic push_hold(input int ch, input int b, input int e);
        ev_t ev;
        int  rel_edge;
        rel_edge = b + e + LAT;
        ev.cyc = b + LAT;
        ev.rel = 1'b0;
        exp_q[ch].push_back(ev);
        if (MASK[ch]) begin
            for (int r = b + LAT + RD; r < rel_edge; r += RP) begin
                ev.cyc = r;
                ev.rel = 1'b0;
                exp_q[ch].push_back(ev);
            end
        end
        ev.cyc = rel_edge;
        ev.rel = 1'b1;
        exp_q[ch].push_back(ev);
    endtask

    task automatic test_reset();
        #1;
        total++;
        if (key_level !== 3'b000) begin
            bad++;
            $display("FAIL reset_level got=%b want=000", key_level);
        end
        total++;
        if (key_press !== 3'b000) begin
            bad++;
            $display("FAIL reset_press got=%b want=000", key_press);
        end
        total++;
        if (key_release !== 3'b000) begin
            bad++;
            $display("FAIL reset_release got=%b want=000", key_release);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        total++;
        if (key_level !== 3'b000) begin
            bad++;
            $display("FAIL idle_level got=%b want=000", key_level);
        end
    endtask

    task automatic test_clean_press(input int ch, input int e);
        int b;
        @(negedge clk);
        ikey[ch] = 1'b0;
        b = cyc + 1;
        push_hold(ch, b, e);
        run_until(b + LAT - 1);
        total++;
        if (key_level[ch] !== 1'b0) begin
            bad++;
            $display("FAIL press_early_level ch=%0d got=%b want=0", ch, key_level[ch]);
        end
        run_until(b + LAT);
        total++;
        if (key_level[ch] !== 1'b1) begin
            bad++;
            $display("FAIL press_accept_level ch=%0d got=%b want=1", ch, key_level[ch]);
        end
        run_until(b + e - 1);
        ikey[ch] = 1'b1;
        run_until(b + e + LAT - 1);
        total++;
        if (key_level[ch] !== 1'b1) begin
            bad++;
            $display("FAIL release_early_level ch=%0d got=%b want=1", ch, key_level[ch]);
        end
        run_until(b + e + LAT);
        total++;
        if (key_level[ch] !== 1'b0 || key_press[ch] !== 1'b0 || key_release[ch] !== 1'b1) begin
            bad++;
            $display("FAIL release_accept ch=%0d got level=%b press=%b release=%b want 0 0 1",
                     ch, key_level[ch], key_press[ch], key_release[ch]);
        end
        run_until(b + e + LAT + 8);
    endtask

    task automatic test_glitch();
        logic pat [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            ikey[1] = pat[j];
            total++;
            if (key_level[1] !== 1'b0) begin
                bad++;
                $display("FAIL glitch_level step=%0d got=%b want=0", j, key_level[1]);
            end
        end
        repeat (10) begin
            @(negedge clk);
            total++;
            if (key_level[1] !== 1'b0) begin
                bad++;
                $display("FAIL glitch_settle_level cycle=%0d got=%b want=0", cyc, key_level[1]);
            end
        end
    endtask

    task automatic test_simultaneous();
        int b;
        @(negedge clk);
        ikey[0] = 1'b0;
        ikey[1] = 1'b0;
        b = cyc + 1;
        push_hold(0, b, 40);
        push_hold(1, b, 20);
        run_until(b + LAT);
        total++;
        if (key_press[1:0] !== 2'b11) begin
            bad++;
            $display("FAIL simul_press got=%b want=11", key_press[1:0]);
        end
        run_until(b + 19);
        ikey[1] = 1'b1;
        run_until(b + 39);
        ikey[0] = 1'b1;
        run_until(b + 40 + LAT + 8);
    endtask

    task automatic test_reset_mid_hold();
        int  b;
        int  b2;
        ev_t ev;
        @(negedge clk);
        ikey[0] = 1'b0;
        b = cyc + 1;
        ev.rel = 1'b0;
        ev.cyc = b + LAT;       exp_q[0].push_back(ev);
        ev.cyc = b + LAT + RD;  exp_q[0].push_back(ev);
        ev.cyc = b + LAT + RD + RP; exp_q[0].push_back(ev);
        run_until(b + 20);
        rst_n = 1'b0;
        #1;
        total++;
        if (key_level !== 3'b000 || key_press !== 3'b000 || key_release !== 3'b000) begin
            bad++;
            $display("FAIL async_reset got level=%b press=%b release=%b want all 0",
                     key_level, key_press, key_release);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        b2 = cyc + 1;
        push_hold(0, b2, 30);
        run_until(b2 + LAT - 1);
        total++;
        if (key_level[0] !== 1'b0) begin
            bad++;
            $display("FAIL reaccept_early_level got=%b want=0", key_level[0]);
        end
        run_until(b2 + LAT);
        total++;
        if (key_level[0] !== 1'b1) begin
            bad++;
            $display("FAIL reaccept_level got=%b want=1", key_level[0]);
        end
        run_until(b2 + 29);
        ikey[0] = 1'b1;
        run_until(b2 + 30 + LAT + 8);
    endtask

    initial begin
        rst_n = 1'b0;
        ikey  = 3'b111;
        repeat (3) @(negedge clk);
        test_reset();
        test_clean_press(0, 50);
        test_glitch();
        test_clean_press(0, 46);
        test_clean_press(2, 46);
        test_simultaneous();
        test_reset_mid_hold();
        for (int ch = 0; ch < NK; ch++) begin
            total++;
            if (exp_q[ch].size() != 0) begin
                bad++;
                $display("FAIL missing_pulses ch=%0d got pending=%0d want 0", ch, exp_q[ch].size());
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
